// File: rtl/fir_engine_if.sv
// fir_engine_if -- signal bundle for fir_engine.
//   in_data/in_valid : signed input sample and its strobe
//   coef_addr        : coefficient ROM address (ROM answers one cycle later)
//   coef_data        : signed coefficient returned by the ROM
//   out_data/out_valid: rounded, saturated result and its one-cycle strobe
//   busy             : convolution in progress
//   overrun          : sticky dropped-sample flag
// master = sample source / ROM side, slave = the filter engine.
interface fir_engine_if;
  logic signed [23:0] in_data;
  logic               in_valid;
  logic        [8:0]  coef_addr;
  logic signed [23:0] coef_data;
  logic signed [23:0] out_data;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output in_data, in_valid, coef_data,
    input  coef_addr, out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_data, in_valid, coef_data,
    output coef_addr, out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/fir_engine.sv
// fir_engine -- sequential single-MAC FIR filter with a TAPS-deep circular
// sample history and an external registered coefficient ROM.
// Parameters: TAPS (filter length / ROM depth), FRAC (coefficient fraction bits).
// Ports: clk, reset_n (async, active-low), bus (fir_engine_if.slave).
// Optional build macro FIR_SYMMETRIC_EN: even-symmetric coefficients, pre-adds
// mirrored taps and sweeps only TAPS/2 coefficient addresses.
module fir_engine #(
  parameter int unsigned TAPS = 492,
  parameter int unsigned FRAC = 22
) (
  input logic        clk,
  input logic        reset_n,
  fir_engine_if.slave bus
);
  localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;
`ifdef FIR_SYMMETRIC_EN
  localparam int unsigned L  = TAPS / 2;
  localparam int unsigned OW = 25;
`else
  localparam int unsigned L  = TAPS;
  localparam int unsigned OW = 24;
`endif
  localparam int unsigned PW = OW + 24;
  localparam logic [AW-1:0] PTR_LAST = AW'(TAPS - 1);
  localparam logic [8:0]    K_LAST   = 9'(L - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
  state_t state, state_next;

  logic signed [23:0]   hist [TAPS];
  logic        [AW-1:0] wp, rp;
`ifdef FIR_SYMMETRIC_EN
  logic        [AW-1:0] rq;
`endif
  logic        [8:0]    k;
  logic signed [OW-1:0] op;
  logic signed [PW-1:0] prod;
  logic                 op_vld, prod_vld;
  logic signed [57:0]   acc;
  logic signed [23:0]   out_data;
  logic                 out_valid, overrun;
  logic                 accept;
  logic signed [57:0]   rnd, shf;
  logic signed [23:0]   sat;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? PTR_LAST : p - AW'(1);
  endfunction

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.coef_addr = (state == ISSUE) ? k : '0;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.overrun   = overrun;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_next = ISSUE;
      ISSUE:   if (k == K_LAST) state_next = DRAIN;
      // Stay until the last operand has moved into the product register; the
      // final product is accumulated on the same edge that enters OUT.
      DRAIN:   if (!op_vld) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rnd = acc + (58'sd1 <<< (FRAC - 1));
    shf = rnd >>> FRAC;
    if (shf > 58'sd8388607)       sat = 24'sh7fffff;
    else if (shf < -58'sd8388608) sat = 24'sh800000;
    else                          sat = shf[23:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[wp] <= bus.in_data;
    end
  end

  // Pipeline: address k issued in ISSUE -> (ROM word, history operand) -> product -> acc.
  // rp starts at the slot just written (x[n]) and walks forward (older samples).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
`ifdef FIR_SYMMETRIC_EN
      rq        <= '0;
`endif
      k         <= '0;
      op        <= '0;
      prod      <= '0;
      op_vld    <= 1'b0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      op_vld    <= (state == ISSUE);
      prod_vld  <= op_vld;
      if (bus.in_valid && (state != IDLE)) overrun <= 1'b1;
      if (accept) begin
        wp  <= ptr_dec(wp);
        rp  <= wp;
`ifdef FIR_SYMMETRIC_EN
        rq  <= ptr_dec(wp);
`endif
        k   <= '0;
        acc <= '0;
      end
      if (state == ISSUE) begin
        k  <= k + 9'd1;
        rp <= ptr_inc(rp);
`ifdef FIR_SYMMETRIC_EN
        rq <= ptr_dec(rq);
        op <= {hist[rp][23], hist[rp]} + {hist[rq][23], hist[rq]};
`else
        op <= hist[rp];
`endif
      end
      if (op_vld) prod <= PW'(op) * PW'(bus.coef_data);
      if (prod_vld) acc <= acc + 58'(prod);
      if (state == OUT) begin
        out_data  <= sat;
        out_valid <= 1'b1;
      end
    end
  end
endmodule
